// File: rtl/y_muldiv_if.sv
// Start/busy/done handshake and operand/result bus for y_muldiv.
// The master side is the EX-stage control; the slave side is the unit.
interface y_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             ex;
    logic             dz;

    modport master (
        output start, op, a, b,
        input  busy, done, z, ex, dz
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, z, ex, dz
    );
endinterface

// File: rtl/y_muldiv.sv
// Multi-cycle M-extension unit: shift-add multiplier, restoring divider.
// Works on magnitudes; the sign is applied in the two-cycle FIX state.
module y_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    y_muldiv_if.slave bus
);
    localparam int W = WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ph_q, ph_d;

    logic [2:0]       op_q;
    logic [W-1:0]     ma_q;
    logic [W-1:0]     mb_q;
    logic [2*W-1:0]   acc_q;
    logic [W:0]       rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     res_q;
    logic [W-1:0]     z_q;
    logic             neg_q;
    logic             byz_q;
    logic             done_q;
    logic             ex_q;
    logic             dz_q;

    logic             accept;
    logic             sa, sb;
    logic             a_neg, b_neg;
    logic             byz_in, sign_in;
    logic [W-1:0]     mag_a, mag_b;

    logic [CNT_W-1:0] cnt_d;
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   mul_nxt;
    logic [W:0]       div_sh, div_try, rem_nxt;
    logic [2*W-1:0]   div_nxt;
    logic [2*W-1:0]   prod_c;
    logic [W-1:0]     quo_c, rem_c, fix_res;
    logic             is_lo, is_hi, is_quo, is_rem;

    assign accept = bus.start && (state_q == IDLE);

    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        unique case (bus.op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sa = 1'b1;
                sb = 1'b1;
            end
            3'b010:  sa = 1'b1;
            default: ;
        endcase
        a_neg   = sa & bus.a[W-1];
        b_neg   = sb & bus.b[W-1];
        mag_a   = a_neg ? -bus.a : bus.a;
        mag_b   = b_neg ? -bus.b : bus.b;
        byz_in  = bus.op[2] & (bus.b == '0);
        // Remainder follows the dividend; everything else is xor.
        sign_in = (bus.op[2] & bus.op[1]) ? a_neg : (a_neg ^ b_neg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = 1'b0;
        unique case (state_q)
            IDLE: if (accept) state_d = byz_in ? FIX : RUN;
            RUN:  if (cnt_d == '0) state_d = FIX;
            FIX: begin
                if (ph_q) state_d = IDLE;
                else      ph_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q - CNT_W'(1);
        mul_sum = {1'b0, acc_q[2*W-1:W]}
                + (acc_q[0] ? {1'b0, ma_q} : '0);
        mul_nxt = {mul_sum, acc_q[W-1:1]};
        div_sh  = {rem_q[W-1:0], acc_q[W-1]};
        div_try = div_sh - {1'b0, mb_q};
        rem_nxt = div_try[W] ? div_sh : div_try;
        div_nxt = {acc_q[2*W-1:W], acc_q[W-2:0], ~div_try[W]};
        prod_c  = neg_q ? -acc_q : acc_q;
        quo_c   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_c   = neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
        is_lo   = (op_q == 3'b000);
        is_hi   = !op_q[2] && (op_q[1:0] != 2'b00);
        is_quo  = op_q[2] && !op_q[1];
        is_rem  = op_q[2] && op_q[1];
        fix_res = '0;
        unique case (1'b1)
            is_lo:   fix_res = prod_c[W-1:0];
            is_hi:   fix_res = prod_c[2*W-1:W];
            is_quo:  fix_res = quo_c;
            is_rem:  fix_res = rem_c;
            default: fix_res = '0;
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.z    = z_q;
    assign bus.ex   = ex_q;
    assign bus.dz   = dz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            ma_q   <= '0;
            mb_q   <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            z_q    <= '0;
            neg_q  <= 1'b0;
            byz_q  <= 1'b0;
            done_q <= 1'b0;
            ex_q   <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (accept) begin
                    op_q  <= bus.op;
                    ma_q  <= mag_a;
                    mb_q  <= mag_b;
                    cnt_q <= CNT_W'(W);
                    rem_q <= '0;
                    byz_q <= byz_in;
                    neg_q <= sign_in & ~byz_in;
                    // Multiplier or dividend sits in the low half.
                    acc_q <= {{W{1'b0}}, (bus.op[2] ? mag_a : mag_b)};
                    if (byz_in) res_q <= bus.op[1] ? bus.a : '1;
                end
                RUN: begin
                    cnt_q <= cnt_d;
                    if (op_q[2]) begin
                        acc_q <= div_nxt;
                        rem_q <= rem_nxt;
                    end else begin
                        acc_q <= mul_nxt;
                    end
                end
                FIX: begin
                    if (!ph_q && !byz_q) res_q <= fix_res;
                    if (ph_q) begin
                        z_q    <= res_q;
                        ex_q   <= (res_q == '0);
                        dz_q   <= byz_q;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/y_muldiv.md
Name: y_muldiv

Overview:
- Parametrised, multi-cycle integer multiply/divide unit.
- Sits beside the yAlu in the EX stage; the control unit drives `start` and `op` (funct3) for M-extension R-type instructions.
- Widens the ALU's combinational arithmetic with a shift-add multiplier and a restoring divider.
- Uses a start/busy/done handshake so the datapath can stall while it runs.

Parameters:
WIDTH, 32, operand and result width in bits (legal range 4..64).
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only on an edge where busy==0
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  WIDTH  operand rs1; sampled on the accepting edge only
b  input  WIDTH  operand rs2; sampled on the accepting edge only
busy  output  1  operation in progress; inputs ignored while high
done  output  1  one-cycle pulse; z is valid from this cycle
z  output  WIDTH  result; held until the next done
ex  output  1  z==0 (same sense as the yAlu zero flag); registered with z
dz  output  1  last operation was a division/remainder by zero; registered with z

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, ex=0, dz=0, z=0.
  - Internal accumulator, operand registers and counter are cleared.
  - Reset during RUN or FIX aborts the operation; no done pulse is produced for it.
- States:
  - IDLE:
    - If start && !busy: latch op, latch |a| and |b| (magnitudes as the op's signedness requires), and record the result sign.
    - Result sign for multiply: sign(a) xor sign(b), counting only the operands that are signed for that op.
    - Result sign for DIV: sign(a) xor sign(b). For REM: sign(a).
    - Set counter=WIDTH, busy=1, state=RUN.
    - Divide-type op with b==0: go to FIX instead of RUN.
  - RUN, multiply: one shift-add step per cycle into a 2*WIDTH-bit product register.
  - RUN, divide: one restoring-division step per cycle; quotient and partial remainder each WIDTH bits, remainder register WIDTH+1 bits.
  - RUN exit: decrement the counter each cycle; leave for FIX on the cycle it reaches 0.
  - FIX: apply two's-complement sign correction and select the result:
    - MUL: product low WIDTH bits.
    - MULH, MULHSU, MULHU: product high WIDTH bits.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
    - Then state=IDLE.
  - Leaving FIX (same edge): z, ex and dz update, busy falls to 0, and done=1 for exactly one cycle.
- Latency, measured from the accepting edge to the edge where done rises:
  - Normal operations: WIDTH+2 edges (WIDTH=32 gives 34).
  - Divide by zero: 2 edges.
- Back-to-back: start is accepted in the done cycle, because busy is already 0. A new operation then begins with no idle bubble.
- start while busy: ignored; the running operation is undisturbed.
- Divide by zero:
  - DIV/DIVU return z = all ones.
  - REM/REMU return z = a (unmodified).
  - dz=1.
- Signed overflow (a = most-negative value, b = -1):
  - DIV returns the most-negative value.
  - REM returns 0.
  - dz=0.
- MULHSU: a is signed, b is unsigned. MULHU and DIVU/REMU are fully unsigned.
- The product must be bit-exact for every WIDTH. Intermediate results are never truncated before FIX.
- Between operations, z, ex and dz hold their last values. done never asserts without a matching accepted start.

Test Plan:
- WIDTH=32, MUL a=7, b=0xFFFFFFFD -> done at edge 34, z=0xFFFFFFEB, ex=0, dz=0; busy high during edges 1..33.
- MULH 0x80000000*0x80000000 -> z=0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> z=0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> z=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> z=0xFFFFFFFD. REM same operands -> z=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> z=0x80000000. REM same operands -> z=0, ex=1.
- DIVU 5/0 -> done 2 edges after accept, z=0xFFFFFFFF, dz=1. REMU 5/0 -> z=5, dz=1.
- Start pulsed again at edge 10 of a MUL -> ignored, single done at edge 34. Start in the done cycle -> accepted, second done 34 edges later. Assert rst at edge 15 -> busy, done, z, ex and dz all 0 immediately; no done follows.
- WIDTH=8 randomized (1000 ops) against a behavioral model -> all z, ex and dz match; latency is 10 edges, or 2 for divide by zero.
